query_loader: RTL
=================

// Module: query_loader
// PURPOSE
//  Host-to-accelerator command path: the opposite direction of the result-drain FIFO/manta readout.
//  Receives 32-bit words written by the host through manta registers (data word + tag).
//  Assembles a frame (header, start vertex, DIM query elements) and presents a stable
//  query/vertex/k to bfis. Fires a one-cycle start and tracks busy until bfis signals done.
// PARAMETERS
//  DIM        4   query vector elements per frame
//  PQ_LENGTH  8   max legal k (priority-queue depth of bfis)
// PORTS
//  clk_in          in   1         system clock (clk_100mhz domain)
//  rst_in          in   1         asynchronous, active-high reset
//  host_word_in    in   32        data word from manta register
//  host_tag_in     in   32        host-written tag; any change = one new word
//  done_in         in   1         bfis search-complete pulse
//  query_out       out  32 x DIM  query vector to bfis, stable from start_out until next start
//  vertex_id_out   out  32        start vertex to bfis
//  k_out           out  16        top-k count to bfis
//  start_out       out  1         one-cycle launch pulse
//  busy_out        out  1         high from start_out through done_in cycle
//  status_out      out  32        manta readback: [2:0] state, [7:4] words_rcvd, [15:8] err_cnt, [23:16] drop_cnt
// BEHAVIOUR
//  Reset (async, rst_in=1): query_out=0, vertex_id_out=0, k_out=0, start_out=0, busy_out=0,
//   status_out=0, tag_q=0, all counters 0, state=S_HDR. Words are never accepted while in reset.
//  Word accept: new_word = (host_tag_in != tag_q); tag_q <= host_tag_in every cycle.
//   host_word_in is sampled on the same edge. A tag already nonzero at reset release counts as one word.
//  Frame: W0 header {8'hA5, 8'h00, k[15:0]}; W1 vertex id; W2..W(DIM+1) query[0..DIM-1].
//  FSM:
//   S_HDR:    on word: if [31:24]==A5 and 1<=k<=PQ_LENGTH, stage k -> S_VTX; else err_cnt++ and stay.
//   S_VTX:    on word: stage vertex -> S_QRY, idx=0.
//   S_QRY:    on word: stage query[idx]; idx==DIM-1 -> S_LAUNCH, else idx++.
//   S_LAUNCH: one cycle: copy staging to outputs, start_out=1, busy_out=1 -> S_RUN.
//   S_RUN:    on done_in: busy_out=0 on the next edge -> S_HDR.
//  Abort: word 32'hDEAD_0000 in S_VTX/S_QRY returns to S_HDR; staging is discarded and outputs
//   are left unchanged.
//  Latency: last query word sampled at edge N -> start_out high in cycle N..N+1, exactly one cycle.
//   Outputs update on the edge that raises start_out.
//  Words arriving in S_LAUNCH/S_RUN are dropped; drop_cnt++. done_in outside S_RUN is ignored.
//  Counters err_cnt and drop_cnt saturate at 255 and do not wrap. words_rcvd wraps modulo 16.
//  query_out is never altered mid-search; staging regs are separate from output regs.
//  Reset mid-frame or mid-search: immediate return to reset state; bfis is reset by the same rst_in.
// STRUCTURE
//  Shared package bfis_pkg: state enum (S_HDR, S_VTX, S_QRY, S_LAUNCH, S_RUN), LD_SYNC=8'hA5,
//   LD_ABORT=32'hDEAD_0000, status bit-field offsets.
//  Sub-module tag_change_detect: registered tag plus compare, emits new_word. Reused by the drain side.
//  Top level: bfis inputs driven from query_out/vertex_id_out/k_out; start_out drives the bfis launch.
// TESTING
//  1 Reset, tags 1..6: A5000004, 1, 5, 7, 1, 1 -> start_out one cycle after tag 6;
//    query_out={5,7,1,1}, vertex=1, k=4, busy_out=1.
//  2 Bad header 12000004, then a valid frame -> err_cnt=1, state stays S_HDR, valid frame launches normally.
//  3 k=0 and k=9 headers (PQ_LENGTH=8) -> both rejected, err_cnt=2, start_out never asserted.
//  4 Valid frame, 3 extra words during S_RUN, then done_in pulse -> drop_cnt=3, query_out unchanged,
//    busy_out low on the following cycle.
//  5 Header, vertex, 2 query words, DEAD0000 -> S_HDR; previous query_out retained; next full frame launches.
//  6 rst_in asserted in S_QRY and in S_RUN -> all outputs 0 asynchronously; after release with tag=0
//    no word is accepted.

Source files
------------

// File: rtl/bfis_pkg.sv
// ----------------------------------------------------------------------------
// bfis_pkg
// Shared definitions for the host command path into bfis and its readout side.
//   ld_state_e    : loader FSM states (encoding is visible in status readback)
//   LD_SYNC       : header sync byte expected in word0[31:24]
//   LD_ABORT      : magic word that aborts a partially received frame
//   ST_*_LSB      : bit offsets of the fields packed into the status word
//   sat_inc8      : 8-bit increment that sticks at 255
// ----------------------------------------------------------------------------
package bfis_pkg;

    typedef enum logic [2:0] {
        S_HDR    = 3'd0,
        S_VTX    = 3'd1,
        S_QRY    = 3'd2,
        S_LAUNCH = 3'd3,
        S_RUN    = 3'd4
    } ld_state_e;

    localparam logic [7:0]  LD_SYNC  = 8'hA5;
    localparam logic [31:0] LD_ABORT = 32'hDEAD_0000;

    localparam int ST_STATE_LSB = 0;
    localparam int ST_WORDS_LSB = 4;
    localparam int ST_ERR_LSB   = 8;
    localparam int ST_DROP_LSB  = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tag_change_detect.sv
// ----------------------------------------------------------------------------
// tag_change_detect
// Turns a host-written tag register into a one-cycle "new word" strobe: the
// tag is registered every cycle and any difference from the registered copy
// means the host has written exactly one new word.
//   clk       in   clock
//   rst       in   asynchronous active-high reset (registered tag clears to 0)
//   tag       in   32-bit host tag
//   new_word  out  high for the cycle in which the tag differs from last cycle
// A tag that is already nonzero when reset releases therefore counts as one
// word, which is intentional: the host may have written during reset.
// ----------------------------------------------------------------------------
module tag_change_detect (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tag,
    output logic        new_word
);

    logic [31:0] tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= tag;
        end
    end

    assign new_word = (tag != tag_reg);

endmodule

// File: rtl/query_loader.sv
// ----------------------------------------------------------------------------
// query_loader
// Host-to-bfis command path. Host words arrive one per tag change and are
// assembled into a frame: header {A5, 00, k}, start vertex, DIM query words.
// A complete frame is copied to the output registers, a one-cycle start is
// fired and busy is held until bfis reports done.
//   clk_in         in   system clock
//   rst_in         in   asynchronous active-high reset
//   host_word_in   in   32-bit data word from the host register
//   host_tag_in    in   host tag; every change delivers one word
//   done_in        in   bfis search-complete pulse
//   query_out      out  DIM x 32 query vector (query_out[i] = element i)
//   vertex_id_out  out  start vertex
//   k_out          out  top-k count
//   start_out      out  one-cycle launch pulse
//   busy_out       out  high from start through the done cycle
//   status_out     out  [2:0] state, [7:4] words_rcvd, [15:8] err_cnt,
//                       [23:16] drop_cnt
// ----------------------------------------------------------------------------
module query_loader #(
    parameter int DIM       = 4,
    parameter int PQ_LENGTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           host_word_in,
    input  logic [31:0]           host_tag_in,
    input  logic                  done_in,
    output logic [DIM-1:0][31:0]  query_out,
    output logic [31:0]           vertex_id_out,
    output logic [15:0]           k_out,
    output logic                  start_out,
    output logic                  busy_out,
    output logic [31:0]           status_out
);
    import bfis_pkg::*;

    localparam int              IDX_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
    localparam logic [15:0]     K_MAX    = 16'(PQ_LENGTH);

    logic        new_word;
    ld_state_e   state_reg, state_next;

    logic        stage_k, stage_vtx, stage_qry, launch, drop, run_done, hdr_bad;
    logic [15:0] hdr_k;

    logic [IDX_W-1:0] idx_reg;
    logic [15:0]      stage_k_reg;
    logic [31:0]      stage_vertex_reg;
    logic [31:0]      stage_query_reg [DIM-1];
    logic [31:0]      launch_word [DIM];

    logic [DIM-1:0][31:0] query_reg;
    logic [31:0]      vertex_reg;
    logic [15:0]      k_reg;
    logic             start_reg, busy_reg;
    logic [7:0]       err_cnt_reg, drop_cnt_reg;
    logic [3:0]       words_rcvd_reg;

    tag_change_detect u_tag (
        .clk      (clk_in),
        .rst      (rst_in),
        .tag      (host_tag_in),
        .new_word (new_word)
    );

    assign hdr_k = host_word_in[15:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= S_HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_k    = 1'b0;
        stage_vtx  = 1'b0;
        stage_qry  = 1'b0;
        launch     = 1'b0;
        drop       = 1'b0;
        run_done   = 1'b0;
        hdr_bad    = 1'b0;
        case (state_reg)
            S_HDR: begin
                if (new_word) begin
                    if (host_word_in[31:24] == LD_SYNC && hdr_k != 16'd0 && hdr_k <= K_MAX) begin
                        stage_k    = 1'b1;
                        state_next = S_VTX;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end
            end
            S_VTX: begin
                if (new_word) begin
                    if (host_word_in == LD_ABORT) begin
                        state_next = S_HDR;
                    end else begin
                        stage_vtx  = 1'b1;
                        state_next = S_QRY;
                    end
                end
            end
            S_QRY: begin
                if (new_word) begin
                    if (host_word_in == LD_ABORT) begin
                        state_next = S_HDR;
                    end else begin
                        stage_qry = 1'b1;
                        if (idx_reg == IDX_LAST) begin
                            // The final query word goes straight to the outputs
                            // on this edge so start_out rises on the edge that
                            // samples it; S_LAUNCH is the start-pulse cycle.
                            launch     = 1'b1;
                            state_next = S_LAUNCH;
                        end
                    end
                end
            end
            S_LAUNCH: begin
                drop       = new_word;
                state_next = S_RUN;
            end
            S_RUN: begin
                drop = new_word;
                if (done_in) begin
                    run_done   = 1'b1;
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // Staging is kept apart from the output registers so a new frame can be
    // received while bfis still reads the previous query.
    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_query
            if (gi < DIM - 1) begin : g_staged
                always_ff @(posedge clk_in or posedge rst_in) begin
                    if (rst_in) begin
                        stage_query_reg[gi] <= '0;
                    end else if (stage_qry && idx_reg == IDX_W'(gi)) begin
                        stage_query_reg[gi] <= host_word_in;
                    end
                end
                assign launch_word[gi] = stage_query_reg[gi];
            end else begin : g_bypass
                assign launch_word[gi] = host_word_in;
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            query_reg <= '0;
        end else if (launch) begin
            for (int i = 0; i < DIM; i++) begin
                query_reg[i] <= launch_word[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_reg          <= '0;
            stage_k_reg      <= '0;
            stage_vertex_reg <= '0;
            vertex_reg       <= '0;
            k_reg            <= '0;
            start_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            err_cnt_reg      <= '0;
            drop_cnt_reg     <= '0;
            words_rcvd_reg   <= '0;
        end else begin
            start_reg <= launch;
            if (stage_k) begin
                stage_k_reg <= hdr_k;
            end
            if (stage_vtx) begin
                stage_vertex_reg <= host_word_in;
                idx_reg          <= '0;
            end else if (stage_qry) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (launch) begin
                vertex_reg <= stage_vertex_reg;
                k_reg      <= stage_k_reg;
                busy_reg   <= 1'b1;
            end else if (run_done) begin
                busy_reg <= 1'b0;
            end
            if (hdr_bad) begin
                err_cnt_reg <= sat_inc8(err_cnt_reg);
            end
            if (drop) begin
                drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            end
            if (new_word) begin
                words_rcvd_reg <= words_rcvd_reg + 4'd1;
            end
        end
    end

    assign query_out     = query_reg;
    assign vertex_id_out = vertex_reg;
    assign k_out         = k_reg;
    assign start_out     = start_reg;
    assign busy_out      = busy_reg;

    always_comb begin
        status_out = '0;
        status_out[ST_STATE_LSB +: 3] = state_reg;
        status_out[ST_WORDS_LSB +: 4] = words_rcvd_reg;
        status_out[ST_ERR_LSB   +: 8] = err_cnt_reg;
        status_out[ST_DROP_LSB  +: 8] = drop_cnt_reg;
    end

endmodule
